// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : shared word width and FSM state encodings for uart_9n1    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package uart_pkg;

  localparam int DATA_BITS = 9;

  // TX_/RX_ prefixes keep the two enums from colliding in one scope
  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_IDLE = 3'd4
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_9n1_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_9n1_if : system-side and pin-side signals of the 9N1 UART       |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface uart_9n1_if;
  import uart_pkg::*;

  logic                 send;
  logic [DATA_BITS-1:0] data_tx;
  logic                 tx;
  logic                 ready;
  logic                 rx;
  logic [DATA_BITS-1:0] data_rx;
  logic                 done;
  logic                 framing_error;

  modport master (
    output send, data_tx, rx,
    input  tx, ready, data_rx, done, framing_error
  );

  modport slave (
    input  send, data_tx, rx,
    output tx, ready, data_rx, done, framing_error
  );

endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx : 9N1 receiver with 2-flop synchronizer and mid-bit sampling |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  wire logic                 clock,
  input  wire logic                 reset,
  input  wire logic                 i_rx,
  output logic [DATA_BITS-1:0]      o_data,
  output logic                      o_done,
  output logic                      o_framing_error
);

  localparam int            CW          = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] c_baud_last = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] c_half_last = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    c_last_bit  = 4'(DATA_BITS - 1);

  rx_state_t            r_state;
  rx_state_t            w_next;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_prev;
  logic [CW-1:0]        r_baud;
  logic [3:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 w_baud_end;
  logic                 w_half_end;

  assign w_baud_end = (r_baud == c_baud_last);
  assign w_half_end = (r_baud == c_half_last);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1         <= 1'b1;
      r_sync2         <= 1'b1;
      r_prev          <= 1'b1;
      r_state         <= RX_IDLE;
      r_baud          <= '0;
      r_bit           <= '0;
      r_shift         <= '0;
      o_data          <= '0;
      o_done          <= 1'b0;
      o_framing_error <= 1'b0;
    end else begin
      r_sync1         <= i_rx;
      r_sync2         <= r_sync1;
      r_prev          <= r_sync2;
      r_state         <= w_next;
      o_done          <= 1'b0;
      o_framing_error <= 1'b0;
      case (r_state)
        RX_START: r_baud <= w_half_end ? '0 : r_baud + 1'b1;
        RX_DATA: begin
          r_baud <= w_baud_end ? '0 : r_baud + 1'b1;
          if (w_baud_end) begin
            r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
            r_bit   <= r_bit + 1'b1;
          end
        end
        RX_STOP: begin
          r_baud <= w_baud_end ? '0 : r_baud + 1'b1;
          if (w_baud_end) begin
            if (r_sync2) begin
              o_data <= r_shift;
              o_done <= 1'b1;
            end else begin
              o_framing_error <= 1'b1;
            end
          end
        end
        default: begin
          r_baud <= '0;
          r_bit  <= '0;
        end
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      RX_IDLE:  if (r_prev && !r_sync2) w_next = RX_START;
      RX_START: if (w_half_end) w_next = r_sync2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (w_baud_end && r_bit == c_last_bit) w_next = RX_STOP;
      RX_STOP:  if (w_baud_end) w_next = r_sync2 ? RX_IDLE : RX_WAIT_IDLE;
      // a stuck-low line must go high before another start edge counts
      RX_WAIT_IDLE: if (r_sync2) w_next = RX_IDLE;
      default:  w_next = RX_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx : 9N1 transmitter, parallel word to LSB-first serial line    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  wire logic                 clock,
  input  wire logic                 reset,
  input  wire logic                 i_send,
  input  wire logic [DATA_BITS-1:0] i_data,
  output logic                      o_tx,
  output logic                      o_ready
);

  localparam int            CW          = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] c_baud_last = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    c_last_bit  = 4'(DATA_BITS - 1);

  tx_state_t            r_state;
  tx_state_t            w_next;
  logic [CW-1:0]        r_baud;
  logic [3:0]           r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 w_baud_end;

  assign w_baud_end = (r_baud == c_baud_last);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= TX_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == TX_IDLE) begin
        r_baud <= '0;
        r_bit  <= '0;
        if (i_send) r_shift <= i_data;
      end else begin
        r_baud <= w_baud_end ? '0 : r_baud + 1'b1;
        // shifter holds the word in flight, so later i_data changes are ignored
        if (r_state == TX_DATA && w_baud_end) begin
          r_shift <= r_shift >> 1;
          r_bit   <= r_bit + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_next  = r_state;
    o_tx    = 1'b1;
    o_ready = 1'b0;
    case (r_state)
      TX_IDLE: begin
        o_ready = 1'b1;
        if (i_send) w_next = TX_START;
      end
      TX_START: begin
        o_tx = 1'b0;
        if (w_baud_end) w_next = TX_DATA;
      end
      TX_DATA: begin
        o_tx = r_shift[0];
        if (w_baud_end && r_bit == c_last_bit) w_next = TX_STOP;
      end
      TX_STOP: begin
        if (w_baud_end) w_next = TX_IDLE;
      end
      default: w_next = TX_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/uart_9n1.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_9n1 : 9N1 UART top, independent TX and RX paths on one clock    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module uart_9n1
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 217
) (
  input  wire logic clock,
  input  wire logic reset,
  uart_9n1_if.slave bus
);

  uart_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx (
    .clock   (clock),
    .reset   (reset),
    .i_send  (bus.send),
    .i_data  (bus.data_tx),
    .o_tx    (bus.tx),
    .o_ready (bus.ready)
  );

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clock           (clock),
    .reset           (reset),
    .i_rx            (bus.rx),
    .o_data          (bus.data_rx),
    .o_done          (bus.done),
    .o_framing_error (bus.framing_error)
  );

endmodule
`default_nettype wire

// File: tb/tb_uart_9n1.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_9n1 : directed loopback and direct-drive bench for uart_9n1  |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_uart_9n1;

  localparam int CPB = 8;

  logic       clock;
  logic       reset;
  logic       r_loop;
  logic       r_rx;
  logic [8:0] exp_word;

  int n_total;
  int n_fail;
  int cyc;
  int done_cnt;
  int fe_cnt;
  int both_cnt;
  int bad_cnt;
  int done_cyc;
  logic [8:0] last_data;

  uart_9n1_if bus ();

  assign bus.rx = r_loop ? bus.tx : r_rx;

  uart_9n1 #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.done) begin
      done_cnt  = done_cnt + 1;
      last_data = bus.data_rx;
      done_cyc  = cyc;
      if (bus.data_rx !== exp_word) bad_cnt = bad_cnt + 1;
    end
    if (bus.framing_error) fe_cnt = fe_cnt + 1;
    if (bus.done && bus.framing_error) both_cnt = both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_frame(input logic [8:0] d, input logic stop_bit);
    r_rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 9; i++) begin
      r_rx = d[i];
      repeat (CPB) @(negedge clock);
    end
    r_rx = stop_bit;
    repeat (CPB) @(negedge clock);
  endtask

  initial begin
    int d0, f0, b0;
    int tx_err, rdy_low, fall_cyc;
    int run, max_run, frames;
    bit started;
    logic [10:0] frame;

    cyc = 0; n_total = 0; n_fail = 0;
    done_cnt = 0; fe_cnt = 0; both_cnt = 0; bad_cnt = 0; done_cyc = 0;
    last_data = '0;
    exp_word = 9'h0D5;
    reset = 1'b1; r_loop = 1'b1; r_rx = 1'b1;
    bus.send = 1'b0; bus.data_tx = '0;
    repeat (4) @(negedge clock);
    check("reset_tx", bus.tx, 1);
    check("reset_ready", bus.ready, 1);
    check("reset_data_rx", bus.data_rx, 0);
    check("reset_done", bus.done, 0);
    check("reset_fe", bus.framing_error, 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // single frame 0x0D5 in loopback
    d0 = done_cnt; f0 = fe_cnt;
    frame = {1'b1, 9'h0D5, 1'b0};
    bus.data_tx = 9'h0D5; bus.send = 1'b1;
    @(negedge clock);
    bus.send = 1'b0;
    fall_cyc = cyc; tx_err = 0; rdy_low = 0;
    for (int i = 0; i < 11 * CPB; i++) begin
      if (bus.tx !== frame[i / CPB]) tx_err++;
      if (bus.ready !== 1'b1) rdy_low++;
      @(negedge clock);
    end
    check("frame_tx_bits", tx_err, 0);
    check("frame_ready_low", rdy_low, 88);
    check("frame_ready_after", bus.ready, 1);
    check("frame_tx_after", bus.tx, 1);
    repeat (20) @(negedge clock);
    check("frame_done_cnt", done_cnt - d0, 1);
    check("frame_data_rx", last_data, 9'h0D5);
    check("frame_fe_cnt", fe_cnt - f0, 0);
    check("frame_latency", ((done_cyc - fall_cyc) <= 88) ? 1 : 0, 1);

    // send held high: back-to-back frames, one idle cycle apart
    d0 = done_cnt; f0 = fe_cnt; b0 = bad_cnt;
    bus.send = 1'b1;
    run = 1; max_run = 0; frames = 0; started = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (bus.ready === 1'b1) run++;
      else begin
        if (run != 0) begin
          if (started && run > max_run) max_run = run;
          frames++;
          started = 1;
        end
        run = 0;
      end
    end
    bus.send = 1'b0;
    repeat (110) @(negedge clock);
    check("burst_frames", frames, 6);
    check("burst_idle_gap", max_run, 1);
    check("burst_done_cnt", done_cnt - d0, 6);
    check("burst_bad_words", bad_cnt - b0, 0);
    check("burst_fe_cnt", fe_cnt - f0, 0);

    // direct drive: bad stop bit, then a good frame
    r_rx = 1'b1; r_loop = 1'b0;
    repeat (5) @(negedge clock);
    d0 = done_cnt; f0 = fe_cnt;
    drive_frame(9'h1FF, 1'b0);
    r_rx = 1'b1;
    repeat (20) @(negedge clock);
    check("ferr_fe_cnt", fe_cnt - f0, 1);
    check("ferr_done_cnt", done_cnt - d0, 0);
    check("ferr_data_kept", bus.data_rx, 9'h0D5);
    exp_word = 9'h001;
    drive_frame(9'h001, 1'b1);
    repeat (20) @(negedge clock);
    check("ferr_recover_done", done_cnt - d0, 1);
    check("ferr_recover_data", bus.data_rx, 9'h001);

    // 2-cycle low glitch rejected, receiver still usable
    d0 = done_cnt; f0 = fe_cnt;
    r_rx = 1'b0;
    repeat (2) @(negedge clock);
    r_rx = 1'b1;
    repeat (30) @(negedge clock);
    check("glitch_done_cnt", done_cnt - d0, 0);
    check("glitch_fe_cnt", fe_cnt - f0, 0);
    exp_word = 9'h0AA;
    drive_frame(9'h0AA, 1'b1);
    repeat (20) @(negedge clock);
    check("glitch_next_done", done_cnt - d0, 1);
    check("glitch_next_data", bus.data_rx, 9'h0AA);

    // reset in the middle of TX DATA
    r_loop = 1'b1;
    repeat (4) @(negedge clock);
    d0 = done_cnt; f0 = fe_cnt;
    bus.data_tx = 9'h1A3; bus.send = 1'b1;
    @(negedge clock);
    bus.send = 1'b0;
    repeat (5 * CPB) @(negedge clock);
    check("abort_tx_low_before", bus.tx, 0);
    reset = 1'b1;
    @(negedge clock);
    check("abort_tx", bus.tx, 1);
    check("abort_ready", bus.ready, 1);
    reset = 1'b0;
    repeat (120) @(negedge clock);
    check("abort_done_cnt", done_cnt - d0, 0);
    check("abort_fe_cnt", fe_cnt - f0, 0);

    // data_tx change after acceptance does not disturb the frame
    d0 = done_cnt;
    exp_word = 9'h055;
    bus.data_tx = 9'h055; bus.send = 1'b1;
    @(negedge clock);
    bus.send = 1'b0; bus.data_tx = 9'h100;
    repeat (110) @(negedge clock);
    check("hold_done_cnt", done_cnt - d0, 1);
    check("hold_data_rx", bus.data_rx, 9'h055);

    check("done_fe_exclusive", both_cnt, 0);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
`default_nettype wire
